// File: rtl/mul4_seq_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// State encodings used by the control FSM.
package mul4_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mul4_seq_fa4.sv
// 4-bit ripple-carry adder, reused as the multiplier's
// only arithmetic element.
module mul4_seq_fa4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[4];

endmodule

// File: rtl/mul4_seq.sv
// Sequential shift-and-add unsigned multiplier with
// a start/done handshake, one partial product per clock.
module mul4_seq
    import mul4_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    logic [1:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic             last;

    assign addend = lo[0] ? mcand : '0;

    if (WIDTH == 4) begin : g_fa4
        mul4_seq_fa4 fa4_inst (
            .a  (hi),
            .b  (addend),
            .ci (1'b0),
            .s  (sum),
            .co (carry)
        );
    end else begin : g_beh
        assign {carry, sum} = {1'b0, hi} + {1'b0, addend};
    end

    // Carry re-enters as the MSB of hi, so nothing is lost.
    assign hi_nxt = {carry, sum[WIDTH-1:1]};
    assign lo_nxt = {sum[0], lo[WIDTH-1:1]};
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            p     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        p     <= {hi_nxt, lo_nxt};
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul4_seq.sv
// Directed bench for mul4_seq with hand-computed products.
// Checks handshake timing, corners, ignore-start and reset abort.
module tb_mul4_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int tests;
    int fails;
    int pulses;

    mul4_seq #(.WIDTH(4), .CNT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full operation; operands scrambled after acceptance.
    task automatic run(input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] exp, input string tag);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 4'($urandom);
        b = 4'($urandom);
        check({tag, " busy0"}, 16'(busy), 16'd1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check({tag, " busy"}, 16'(busy), 16'd1);
            check({tag, " nodone"}, 16'(done), 16'd0);
        end
        tick();
        check({tag, " done"}, 16'(done), 16'd1);
        check({tag, " busyoff"}, 16'(busy), 16'd0);
        check({tag, " p"}, 16'(p), 16'(exp));
        tick();
        check({tag, " doneoff"}, 16'(done), 16'd0);
        check({tag, " hold"}, 16'(p), 16'(exp));
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        start = 1'b1;
        a = 4'd13;
        b = 4'd11;

        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst busy", 16'(busy), 16'd0);
            check("rst done", 16'(done), 16'd0);
            check("rst p", 16'(p), 16'h00);
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("post-rst idle", 16'(busy), 16'd0);

        run(4'd13, 4'd11, 8'h8F, "13x11");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle hold", 16'(p), 16'h8F);
        end

        run(4'd15, 4'd15, 8'hE1, "15x15");
        run(4'd0, 4'd9, 8'h00, "0x9");
        run(4'd7, 4'd0, 8'h00, "7x0");
        run(4'd1, 4'd1, 8'h01, "1x1");

        // start re-asserted during BUSY is ignored
        a = 4'd5;
        b = 4'd6;
        start = 1'b1;
        tick();
        a = 4'd2;
        b = 4'd3;
        pulses = 0;
        for (int i = 1; i < 4; i++) begin
            tick();
            check("ign busy", 16'(busy), 16'd1);
        end
        tick();
        start = 1'b0;
        check("ign done", 16'(done), 16'd1);
        check("ign p", 16'(p), 16'h1E);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) pulses++;
        end
        check("ign pulses", 16'(pulses), 16'd0);
        check("ign hold", 16'(p), 16'h1E);

        // back-to-back with start held high
        a = 4'd3;
        b = 4'd4;
        start = 1'b1;
        tick();
        a = 4'd9;
        b = 4'd9;
        for (int i = 1; i < 4; i++) tick();
        tick();
        check("b2b done1", 16'(done), 16'd1);
        check("b2b p1", 16'(p), 16'h0C);
        tick();
        start = 1'b0;
        check("b2b rebusy", 16'(busy), 16'd1);
        check("b2b gap", 16'(done), 16'd0);
        for (int i = 6; i < 9; i++) begin
            tick();
            check("b2b busy", 16'(busy), 16'd1);
        end
        tick();
        check("b2b done2", 16'(done), 16'd1);
        check("b2b p2", 16'(p), 16'h51);
        tick();

        // reset on the second BUSY cycle aborts
        a = 4'd15;
        b = 4'd15;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("abort busy2", 16'(busy), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 16'(busy), 16'd0);
        check("abort done", 16'(done), 16'd0);
        check("abort p", 16'(p), 16'h00);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort pulses", 16'(pulses), 16'd0);
        check("abort p0", 16'(p), 16'h00);

        run(4'd2, 4'd8, 8'h10, "2x8");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
